// File: rtl/postfix_pkg.sv
// Shared definitions for the infix-to-postfix converter and the postfix evaluator:
// token encoding, operator codes/precedence, converter FSM state codes and default depths.
package postfix_pkg;

  localparam int QDEPTH_DEF = 32;
  localparam int SDEPTH_DEF = 16;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_LPAR = 4'b1000;
  localparam logic [3:0] OP_RPAR = 4'b1001;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_CONVERT = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;

  // mode 0 = operand value, mode 1 = operator/parenthesis code
  typedef struct packed {
    logic       mode;
    logic [3:0] val;
  } tok_t;

  function automatic logic [1:0] op_prec(input logic [3:0] code);
    case (code)
      OP_MUL:         return 2'd2;
      OP_ADD, OP_SUB: return 2'd1;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic logic is_arith(input logic [3:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
  endfunction

endpackage

// File: rtl/infix2postfix_if.sv
// Token stream interface: infix tokens in, postfix tokens out, plus status.
// No backpressure: the producer sends one burst and the consumer takes every emitted token.
interface infix2postfix_if;
  logic       in_valid;
  logic       op_mode;
  logic [3:0] in;
  logic       out_valid;
  logic       out_mode;
  logic [3:0] out;
  logic       busy;
  logic       err;

  modport master (
    output in_valid, op_mode, in,
    input  out_valid, out_mode, out, busy, err
  );

  modport slave (
    input  in_valid, op_mode, in,
    output out_valid, out_mode, out, busy, err
  );
endinterface

// File: rtl/tok_fifo.sv
// Token queue with show-ahead read data (rd_dat is the head entry while !empty).
// Writes when full and reads when empty are ignored; clr empties the queue in one cycle.
module tok_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic             last
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_wr, do_rd;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign last   = (cnt_q == CW'(1));
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_wr) wr_ptr_d = nxt(wr_ptr_q);
      if (do_rd) rd_ptr_d = nxt(rd_ptr_q);
      cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/infix2postfix.sv
// Shunting-yard converter: buffers one infix burst, converts one action per cycle, then
// streams the postfix result gap-free. No backpressure; tokens arriving while busy are dropped.
module infix2postfix
  import postfix_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF,
  parameter int SDEPTH = SDEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  infix2postfix_if.slave io
);
  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int SIW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam int TW  = $bits(tok_t);

  logic [2:0]     st_q, st_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           skip_q, skip_d;
  logic           err_q, err_d;

  logic [3:0]     stk_mem [SDEPTH];
  logic [SIW-1:0] top_idx, push_idx;
  logic [3:0]     top_op;
  logic           stk_empty, stk_full, stk_push, abort;

  tok_t in_wdat, in_rd, out_wdat, out_rd;
  logic in_push, in_pop, in_full, in_empty, in_last;
  logic out_push, out_pop, out_full, out_empty, out_last;
  logic q_clr, out_vld;

  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SPW'(SDEPTH));
  assign top_idx   = SIW'(sp_q - SPW'(1));
  assign push_idx  = SIW'(sp_q);
  assign top_op    = stk_mem[top_idx];
  assign in_wdat   = {io.op_mode, io.in};

  tok_fifo #(.WIDTH(TW), .DEPTH(QDEPTH)) u_inq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (q_clr),
    .wr_en  (in_push),
    .wr_dat (in_wdat),
    .rd_en  (in_pop),
    .rd_dat (in_rd),
    .full   (in_full),
    .empty  (in_empty),
    .last   (in_last)
  );

  tok_fifo #(.WIDTH(TW), .DEPTH(QDEPTH)) u_outq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (q_clr),
    .wr_en  (out_push && !out_full),
    .wr_dat (out_wdat),
    .rd_en  (out_pop),
    .rd_dat (out_rd),
    .full   (out_full),
    .empty  (out_empty),
    .last   (out_last)
  );

  always_comb begin
    st_d     = st_q;
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    err_d    = 1'b0;
    // a burst that starts while busy is swallowed until in_valid drops
    skip_d   = io.in_valid && (skip_q || ((st_q != ST_IDLE) && (st_q != ST_LOAD)));
    in_push  = 1'b0;
    in_pop   = 1'b0;
    out_push = 1'b0;
    out_wdat = in_rd;
    out_pop  = 1'b0;
    stk_push = 1'b0;
    abort    = 1'b0;
    q_clr    = 1'b0;

    case (st_q)
      ST_IDLE: begin
        if (io.in_valid && !skip_q) begin
          in_push = 1'b1;
          ovf_d   = 1'b0;
          st_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (io.in_valid) begin
          if (in_full) ovf_d = 1'b1;
          else         in_push = 1'b1;
        end else begin
          err_d = ovf_q;
          st_d  = ST_CONVERT;
        end
      end

      ST_CONVERT: begin
        if (in_empty) begin
          st_d = ST_DRAIN;
        end else if (!in_rd.mode) begin
          out_push = 1'b1;
          in_pop   = 1'b1;
        end else begin
          case (in_rd.val)
            OP_LPAR: begin
              if (stk_full) abort = 1'b1;
              else begin
                stk_push = 1'b1;
                sp_d     = sp_q + SPW'(1);
                in_pop   = 1'b1;
              end
            end
            OP_RPAR: begin
              if (stk_empty) begin
                abort = 1'b1;
              end else if (top_op == OP_LPAR) begin
                sp_d   = sp_q - SPW'(1);
                in_pop = 1'b1;
              end else begin
                out_push = 1'b1;
                out_wdat = {1'b1, top_op};
                sp_d     = sp_q - SPW'(1);
              end
            end
            OP_ADD, OP_SUB, OP_MUL: begin
              // left associativity: equal precedence on the stack is popped first
              if (!stk_empty && is_arith(top_op) && (op_prec(top_op) >= op_prec(in_rd.val))) begin
                out_push = 1'b1;
                out_wdat = {1'b1, top_op};
                sp_d     = sp_q - SPW'(1);
              end else if (stk_full) begin
                abort = 1'b1;
              end else begin
                stk_push = 1'b1;
                sp_d     = sp_q + SPW'(1);
                in_pop   = 1'b1;
              end
            end
            default: abort = 1'b1;
          endcase
          if (in_pop && in_last) st_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (stk_empty) begin
          st_d = ST_EMIT;
        end else if (top_op == OP_LPAR) begin
          abort = 1'b1;
        end else begin
          out_push = 1'b1;
          out_wdat = {1'b1, top_op};
          sp_d     = sp_q - SPW'(1);
        end
      end

      ST_EMIT: begin
        if (out_empty) begin
          st_d = ST_IDLE;
        end else begin
          out_pop = 1'b1;
          if (out_last) st_d = ST_IDLE;
        end
      end

      default: st_d = ST_IDLE;
    endcase

    if (abort) begin
      err_d    = 1'b1;
      q_clr    = 1'b1;
      sp_d     = '0;
      stk_push = 1'b0;
      st_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      skip_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      skip_q <= skip_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stk_push) stk_mem[push_idx] <= in_rd.val;
  end

  // output path is combinational from state so reset silences it without waiting for a clock
  assign out_vld      = (st_q == ST_EMIT) && !out_empty;
  assign io.out_valid = out_vld;
  assign io.out_mode  = out_vld && out_rd.mode;
  assign io.out       = out_vld ? out_rd.val : 4'd0;
  assign io.busy      = (st_q != ST_IDLE);
  assign io.err       = err_q;

endmodule

// File: tb/tb_infix2postfix.sv
// Directed bench for infix2postfix: hand-written infix streams and expected postfix streams,
// error/overflow cases, asynchronous reset mid-stream, and a loopback through a postfix evaluator.
module tb_infix2postfix;
  import postfix_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nvec  = 0;
  int   nerr  = 0;

  logic [4:0] stim_q[$];
  logic [4:0] exp_q[$];
  logic [4:0] got_q[$];
  int         errs, bursts, idle_bad, seen, vld_cnt, busy_cnt;
  logic       timed_out;

  localparam logic [4:0] T_ADD = {1'b1, OP_ADD};
  localparam logic [4:0] T_SUB = {1'b1, OP_SUB};
  localparam logic [4:0] T_MUL = {1'b1, OP_MUL};
  localparam logic [4:0] T_LP  = {1'b1, OP_LPAR};
  localparam logic [4:0] T_RP  = {1'b1, OP_RPAR};
  localparam logic [4:0] T_BAD = 5'h13;

  infix2postfix_if io ();

  infix2postfix dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] num(input int v);
    return {1'b0, 4'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eval_postfix(input logic [4:0] q[$]);
    int st[$];
    int a, b;
    foreach (q[i]) begin
      if (!q[i][4]) begin
        st.push_back(int'(q[i][3:0]));
      end else begin
        if (st.size() < 2) return -1;
        b = st.pop_back();
        a = st.pop_back();
        case (q[i][3:0])
          OP_ADD:  st.push_back(a + b);
          OP_SUB:  st.push_back(a - b);
          OP_MUL:  st.push_back(a * b);
          default: return -1;
        endcase
      end
    end
    return (st.size() == 1) ? st[0] : -1;
  endfunction

  // called at a negedge; drives one token per cycle and leaves in_valid low at a negedge
  task automatic send();
    foreach (stim_q[i]) begin
      io.in_valid = 1'b1;
      {io.op_mode, io.in} = stim_q[i];
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    io.op_mode  = 1'b0;
    io.in       = 4'd0;
  endtask

  task automatic run_case(input string tag, input int exp_err);
    logic prev;
    got_q.delete();
    errs = 0; bursts = 0; idle_bad = 0; timed_out = 1'b1; prev = 1'b0;
    send();
    for (int c = 0; c < 400; c++) begin
      if (io.err) errs++;
      if (io.out_valid) begin
        got_q.push_back({io.out_mode, io.out});
        if (!prev) bursts++;
      end else if (io.out_mode !== 1'b0 || io.out !== 4'd0) begin
        idle_bad++;
      end
      prev = io.out_valid;
      if (!io.busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " finished"}, 32'(timed_out), 32'd0);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size()) chk($sformatf("%s tok%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, " bursts"}, bursts, (exp_q.size() > 0) ? 1 : 0);
    chk({tag, " err pulses"}, errs, exp_err);
    chk({tag, " idle outputs"}, idle_bad, 0);
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.op_mode  = 1'b0;
    io.in       = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(io.out_valid), 32'd0);
    chk("reset out_mode", 32'(io.out_mode), 32'd0);
    chk("reset out", 32'(io.out), 32'd0);
    chk("reset busy", 32'(io.busy), 32'd0);
    chk("reset err", 32'(io.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    stim_q = {num(3), T_ADD, num(4), T_MUL, num(2)};
    exp_q  = {num(3), num(4), num(2), T_MUL, T_ADD};
    run_case("3+4*2", 0);

    stim_q = {T_LP, num(1), T_ADD, num(2), T_RP, T_MUL, num(3)};
    exp_q  = {num(1), num(2), T_ADD, num(3), T_MUL};
    run_case("(1+2)*3", 0);

    stim_q = {num(8), T_SUB, num(3), T_SUB, num(2)};
    exp_q  = {num(8), num(3), T_SUB, num(2), T_SUB};
    run_case("8-3-2", 0);

    stim_q = {num(1), T_ADD, num(2), T_RP};
    exp_q  = {};
    run_case("1+2)", 1);
    chk("after 1+2) busy", 32'(io.busy), 32'd0);

    stim_q = {num(5)};
    exp_q  = {num(5)};
    run_case("5", 0);

    stim_q = {num(1), T_BAD, num(2)};
    exp_q  = {};
    run_case("illegal code", 1);

    stim_q.delete();
    repeat (17) stim_q.push_back(T_LP);
    exp_q = {};
    run_case("stack overflow", 1);

    stim_q.delete();
    repeat (16) stim_q.push_back(T_LP);
    stim_q.push_back(num(7));
    repeat (15) stim_q.push_back(T_RP);
    exp_q = {};
    run_case("lparen left in drain", 1);

    // 34-token burst: the last two tokens are dropped, the kept 32 still convert
    stim_q.delete();
    for (int i = 0; i < 34; i++) stim_q.push_back((i % 2 == 0) ? num((i / 2) % 16) : T_ADD);
    exp_q = {num(0)};
    for (int k = 1; k < 16; k++) begin
      exp_q.push_back(num(k));
      exp_q.push_back(T_ADD);
    end
    exp_q.push_back(T_ADD);
    run_case("queue overflow", 1);

    stim_q = {num(9), T_MUL, num(9), T_MUL, num(9)};
    send();
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (io.out_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("9*9*9 first out_valid", seen, 1);
    @(negedge clk);
    chk("9*9*9 2nd out_valid", 32'(io.out_valid), 32'd1);
    chk("9*9*9 2nd token", 32'({io.out_mode, io.out}), 32'(num(9)));
    #1 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(io.out_valid), 32'd0);
    chk("async rst out_mode", 32'(io.out_mode), 32'd0);
    chk("async rst out", 32'(io.out), 32'd0);
    chk("async rst busy", 32'(io.busy), 32'd0);
    chk("async rst err", 32'(io.err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    busy_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (io.out_valid) vld_cnt++;
      if (io.busy) busy_cnt++;
    end
    chk("post reset out_valid cycles", vld_cnt, 0);
    chk("post reset busy cycles", busy_cnt, 0);

    stim_q = {num(7)};
    exp_q  = {num(7)};
    run_case("7 after reset", 0);

    stim_q = {num(2), T_MUL, T_LP, num(3), T_ADD, num(4), T_RP, T_SUB, num(5)};
    exp_q  = {num(2), num(3), num(4), T_ADD, T_MUL, num(5), T_SUB};
    run_case("2*(3+4)-5", 0);
    chk("loopback result", 32'(eval_postfix(got_q)), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
